// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake between the D stage and the hazard controller.
// The master (decode) drives the D-stage fields; the slave returns selects and stall controls.
interface hazard_ctrl_if;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [1:0] Tuse_rs;
    logic [1:0] Tuse_rt;
    logic [4:0] A3_D;
    logic       regWrite_D;
    logic [1:0] Tnew_D;
    logic [1:0] md_op_D;
    logic       md_use_D;
    logic [1:0] RD1_sel;
    logic [1:0] RD2_sel;
    logic       stall;
    logic       clr_E;
    logic       md_busy;

    modport master (
        output A1_D, A2_D, Tuse_rs, Tuse_rt, A3_D, regWrite_D, Tnew_D, md_op_D, md_use_D,
        input  RD1_sel, RD2_sel, stall, clr_E, md_busy
    );

    modport slave (
        input  A1_D, A2_D, Tuse_rs, Tuse_rt, A3_D, regWrite_D, Tnew_D, md_op_D, md_use_D,
        output RD1_sel, RD2_sel, stall, clr_E, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core: tracks E/M/W destinations to drive
// Decode forwarding selects, F/D stall, E bubble and the mult/div busy counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYC);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYC);

    logic       wr_e_q, wr_m_q, wr_w_q;
    logic [4:0] a3_e_q, a3_m_q, a3_w_q;
    logic [1:0] tnew_e_q, tnew_m_q;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       md_e_q, md_mult_q;

    logic       md_start_d;
    logic       data_stall;
    logic       md_stall;
    logic       stall;
    logic [1:0] tnew_m_d;

    // W-stage Tnew is always 0 once there, so it is not stored.
    function automatic logic [1:0] fwd_sel(input logic [4:0] a);
        logic [1:0] sel;
        sel = 2'b00;
        if (a != 5'd0) begin
            if (wr_m_q && (a3_m_q == a) && (tnew_m_q == 2'd0)) begin
                sel = 2'b10;
            end else if (wr_w_q && (a3_w_q == a)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    function automatic logic src_stall(input logic [4:0] a, input logic [1:0] tuse);
        logic st;
        st = 1'b0;
        if ((tuse != 2'd3) && (a != 5'd0)) begin
            if (wr_e_q && (a3_e_q == a) && (tnew_e_q > tuse)) st = 1'b1;
            if (wr_m_q && (a3_m_q == a) && (tnew_m_q > tuse)) st = 1'b1;
        end
        return st;
    endfunction

    always_comb begin
        data_stall = src_stall(hz.A1_D, hz.Tuse_rs) | src_stall(hz.A2_D, hz.Tuse_rt);
        md_stall   = hz.md_use_D & ((md_cnt_q != 4'd0) | md_e_q);
        stall      = data_stall | md_stall;
        md_start_d = (hz.md_op_D == 2'b01) || (hz.md_op_D == 2'b10);
        tnew_m_d   = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_e_q) begin
            md_cnt_d = md_mult_q ? MultLoad : DivLoad;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_e_q    <= 1'b0;
            a3_e_q    <= 5'd0;
            tnew_e_q  <= 2'd0;
            md_e_q    <= 1'b0;
            md_mult_q <= 1'b0;
            wr_m_q    <= 1'b0;
            a3_m_q    <= 5'd0;
            tnew_m_q  <= 2'd0;
            wr_w_q    <= 1'b0;
            a3_w_q    <= 5'd0;
            md_cnt_q  <= 4'd0;
        end else begin
            if (stall) begin
                wr_e_q <= 1'b0;
                md_e_q <= 1'b0;
            end else begin
                wr_e_q    <= hz.regWrite_D & (hz.A3_D != 5'd0);
                a3_e_q    <= hz.A3_D;
                tnew_e_q  <= hz.Tnew_D;
                md_e_q    <= md_start_d;
                md_mult_q <= (hz.md_op_D == 2'b01);
            end
            wr_m_q   <= wr_e_q;
            a3_m_q   <= a3_e_q;
            tnew_m_q <= tnew_m_d;
            wr_w_q   <= wr_m_q;
            a3_w_q   <= a3_m_q;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign hz.RD1_sel = fwd_sel(hz.A1_D);
    assign hz.RD2_sel = fwd_sel(hz.A2_D);
    assign hz.stall   = stall;
    assign hz.clr_E   = stall;
    assign hz.md_busy = (md_cnt_q != 4'd0);

endmodule
